// File: rtl/somador_serial8.sv
// Bit-serial unsigned adder: adds a and b one bit per clock, LSB first,
// and presents the N+1 bit sum with a one-cycle done pulse.
module somador_serial8 #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   s,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  acc;
    logic          c;
    logic [CW-1:0] cnt;

    logic          sum_bit;
    logic          c_next;
    logic [N-1:0]  acc_next;

    // Full-adder slice on the current LSBs and the running carry.
    always_comb begin
        sum_bit  = a_sh[0] ^ b_sh[0] ^ c;
        c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        acc_next = {sum_bit, acc[N-1:1]};
    end

    // The accumulator LSB shifts out before it ever holds a result bit.
    logic acc_lsb_unused;
    assign acc_lsb_unused = acc[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= c_next;
                    acc  <= acc_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        s     <= {c_next, acc_next};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_somador_serial8.sv
// Scoreboard bench for somador_serial8: stimulus pushes expected sums,
// a negedge monitor pops and compares them whenever done is seen.
module tb_somador_serial8;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N:0]   s;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int overlap_cycles = 0;
    logic [N:0] exp_q[$];

    somador_serial8 #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    // Monitor: compare s against the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n && busy && done) overlap_cycles++;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(s), 32'hFFFF_FFFF);
            end else begin
                check("sum", 32'(s), 32'(exp_q.pop_front()));
            end
        end
    end

    // Called at a negedge while busy; returns edges until done is sampled.
    task automatic wait_done(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (n < 40) begin
            if (!busy || done) busy_ok = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) return;
        end
    endtask

    task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [N:0] ex);
        @(negedge clk);
        start = 1'b1;
        a = av;
        b = bv;
        exp_q.push_back(ex);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_op(input string tag, input int lat_req);
        int  n;
        bit  bok;
        wait_done(n, bok);
        check({tag, "_latency"}, 32'(n), 32'(lat_req));
        check({tag, "_busy_window"}, 32'(bok), 32'd1);
        check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int  n;
        bit  bok;
        int  spur;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        check("reset_s", 32'(s), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zeros and the all-ones no-wrap case.
        launch(8'h00, 8'h00, 9'h000);
        finish_op("zero", 8);
        launch(8'hFF, 8'hFF, 9'h1FE);
        finish_op("max", 8);
        check("max_carry_out", 32'(s[N]), 32'd1);

        // Start and operands driven mid-operation must be ignored.
        launch(8'd200, 8'd100, 9'd300);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a = 8'd1;
        b = 8'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = '0;
        b = '0;
        wait_done(n, bok);
        check("ignore_latency", 32'(n), 32'd5);
        repeat (3) @(negedge clk);
        check("s_hold", 32'(s), 32'd300);
        check("idle_after_ignore", 32'(busy), 32'd0);

        // Start held high: back-to-back operations, operands changed during CALC.
        @(negedge clk);
        start = 1'b1;
        a = 8'h0F;
        b = 8'h01;
        exp_q.push_back(9'h010);
        @(posedge clk);
        @(negedge clk);
        a = 8'h80;
        b = 8'h80;
        exp_q.push_back(9'h100);
        wait_done(n, bok);
        check("b2b_first_latency", 32'(n), 32'd8);
        check("b2b_first_busy", 32'(bok), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_second_accepted", 32'(busy), 32'd1);
        start = 1'b0;
        a = '0;
        b = '0;
        wait_done(n, bok);
        check("b2b_second_latency", 32'(n), 32'd8);
        check("b2b_second_busy", 32'(bok), 32'd1);
        @(negedge clk);

        // Asynchronous reset mid-operation aborts with no done.
        @(negedge clk);
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_s", 32'(s), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        spur = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) spur++;
        end
        check("abort_no_done", 32'(spur), 32'd0);

        launch(8'd1, 8'd2, 9'd3);
        finish_op("post_reset", 8);

        repeat (3) @(negedge clk);
        check("busy_done_overlap", 32'(overlap_cycles), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
